// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit port.
// Used by uart_tx_port; the UART_TX_PARITY_EN option relies on the S_PARITY state defined here.
package uart_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } tx_state_t;

   localparam int DATA_BITS = 8;

   // Bit positions inside the status word
   localparam int STAT_FULL = 0;
   localparam int STAT_BUSY = 1;
   localparam int STAT_OVF  = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit FIFO with a show-ahead read port; dout always shows the oldest entry.
// DEPTH must be a power of two so the pointers wrap on their own.
module uart_tx_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wrPtr;
   logic [AW-1:0]    r_rdPtr;
   logic [AW:0]      r_count;
   logic             w_doPush;
   logic             w_doPop;

   assign full     = (r_count == (AW+1)'(DEPTH));
   assign empty    = (r_count == '0);
   assign w_doPush = push && !full;
   assign w_doPop  = pop && !empty;
   assign dout     = r_mem[r_rdPtr];

   // Storage carries no reset; only the pointers and count define validity
   always_ff @(posedge CLK) begin
      if (w_doPush) begin
         r_mem[r_wrPtr] <= din;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_doPush) begin
            r_wrPtr <= r_wrPtr + 1'b1;
         end
         if (w_doPop) begin
            r_rdPtr <= r_rdPtr + 1'b1;
         end
         case ({w_doPush, w_doPop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx_port.sv
// Memory-mapped UART transmitter: byte writes to TX_ADDR are queued and sent 8N1.
// Define UART_TX_PARITY_EN to insert an even-parity bit after the data bits (8E1).
module uart_tx_port
   import uart_pkg::*;
#(
   parameter int          CLK_HZ     = 100000000,
   parameter int          BAUD       = 115200,
   parameter logic [7:0]  TX_ADDR    = 8'hF0,
   parameter logic [7:0]  STAT_ADDR  = 8'hF1,
   parameter int          FIFO_DEPTH = 4
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [7:0]  address,
   input  logic        write_en,
   input  logic        read_en,
   input  logic [15:0] input_data,
   output logic [15:0] output_data,
   output logic        UART_RXD_OUT
);

   localparam int             DIV      = CLK_HZ / BAUD;
   localparam int             CW       = $clog2(DIV + 1);
   localparam logic [CW-1:0]  DIV_LAST = CW'(DIV - 1);
   localparam logic [2:0]     BIT_LAST = 3'(DATA_BITS - 1);

   tx_state_t     r_state;
   logic [7:0]    r_shift;
   logic [CW-1:0] r_baudCnt;
   logic [2:0]    r_bitCnt;
   logic          r_line;
   logic          r_ovf;
`ifdef UART_TX_PARITY_EN
   logic          r_parity;
`endif

   logic          w_full;
   logic          w_empty;
   logic [7:0]    w_dout;
   logic          w_pop;
   logic          w_wrTx;
   logic          w_rdStat;
   logic          w_busy;
   logic          w_baudDone;
   logic          w_unused;

   assign w_unused   = &{1'b0, input_data[15:8]};
   assign w_wrTx     = write_en && (address == TX_ADDR);
   assign w_rdStat   = read_en && (address == STAT_ADDR);
   assign w_baudDone = (r_baudCnt == DIV_LAST);
   assign w_busy     = (r_state != S_IDLE) || !w_empty;
   assign w_pop      = !w_empty && ((r_state == S_IDLE) || ((r_state == S_STOP) && w_baudDone));
   assign UART_RXD_OUT = r_line;

   uart_tx_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .CLK   (CLK),
      .RST   (RST),
      .push  (w_wrTx),
      .pop   (w_pop),
      .din   (input_data[7:0]),
      .dout  (w_dout),
      .full  (w_full),
      .empty (w_empty)
   );

   // The line is registered alongside the state so every bit boundary is glitch-free
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_shift   <= '0;
         r_baudCnt <= '0;
         r_bitCnt  <= '0;
         r_line    <= 1'b1;
`ifdef UART_TX_PARITY_EN
         r_parity  <= 1'b0;
`endif
      end else begin
         case (r_state)
            S_IDLE: begin
               r_line    <= 1'b1;
               r_baudCnt <= '0;
               r_bitCnt  <= '0;
               if (!w_empty) begin
                  r_shift <= w_dout;
`ifdef UART_TX_PARITY_EN
                  r_parity <= ^w_dout;
`endif
                  r_line  <= 1'b0;
                  r_state <= S_START;
               end
            end
            S_START: begin
               if (w_baudDone) begin
                  r_baudCnt <= '0;
                  r_line    <= r_shift[0];
                  r_state   <= S_DATA;
               end else begin
                  r_baudCnt <= r_baudCnt + 1'b1;
               end
            end
            S_DATA: begin
               if (w_baudDone) begin
                  r_baudCnt <= '0;
                  if (r_bitCnt == BIT_LAST) begin
                     r_bitCnt <= '0;
`ifdef UART_TX_PARITY_EN
                     r_line   <= r_parity;
                     r_state  <= S_PARITY;
`else
                     r_line   <= 1'b1;
                     r_state  <= S_STOP;
`endif
                  end else begin
                     r_bitCnt <= r_bitCnt + 1'b1;
                     r_shift  <= {1'b0, r_shift[7:1]};
                     r_line   <= r_shift[1];
                  end
               end else begin
                  r_baudCnt <= r_baudCnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
               if (w_baudDone) begin
                  r_baudCnt <= '0;
                  r_line    <= 1'b1;
                  r_state   <= S_STOP;
               end else begin
                  r_baudCnt <= r_baudCnt + 1'b1;
               end
            end
`endif
            S_STOP: begin
               if (w_baudDone) begin
                  r_baudCnt <= '0;
                  if (!w_empty) begin
                     r_shift <= w_dout;
`ifdef UART_TX_PARITY_EN
                     r_parity <= ^w_dout;
`endif
                     r_line  <= 1'b0;
                     r_state <= S_START;
                  end else begin
                     r_line  <= 1'b1;
                     r_state <= S_IDLE;
                  end
               end else begin
                  r_baudCnt <= r_baudCnt + 1'b1;
               end
            end
            default: begin
               r_line    <= 1'b1;
               r_baudCnt <= '0;
               r_bitCnt  <= '0;
               r_state   <= S_IDLE;
            end
         endcase
      end
   end

   // An overflow in the same cycle as a status read wins, so it is never lost
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_ovf <= 1'b0;
      end else if (w_wrTx && w_full) begin
         r_ovf <= 1'b1;
      end else if (w_rdStat) begin
         r_ovf <= 1'b0;
      end
   end

   always_comb begin
      output_data = '0;
      if (w_rdStat) begin
         output_data[STAT_FULL] = w_full;
         output_data[STAT_BUSY] = w_busy;
         output_data[STAT_OVF]  = r_ovf;
      end
   end

endmodule

// File: tb/tb_uart_tx_port.sv
// Self-checking bench for uart_tx_port: directed steps plus a line decoder feeding a byte scoreboard.
// Honours UART_TX_PARITY_EN when the design is built with it.
module tb_uart_tx_port;

   localparam int DIV = 100000000 / 115200;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int FRAME = NBITS * DIV;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  address = '0;
   logic        write_en = 1'b0;
   logic        read_en = 1'b0;
   logic [15:0] input_data = '0;
   logic [15:0] output_data;
   logic        line;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          monFrames = 0;
   logic [7:0]  expQ[$];
   int          startStamps[$];

   uart_tx_port #(
      .CLK_HZ     (100000000),
      .BAUD       (115200),
      .TX_ADDR    (8'hF0),
      .STAT_ADDR  (8'hF1),
      .FIFO_DEPTH (4)
   ) dut (
      .CLK          (clk),
      .RST          (rst),
      .address      (address),
      .write_en     (write_en),
      .read_en      (read_en),
      .input_data   (input_data),
      .output_data  (output_data),
      .UART_RXD_OUT (line)
   );

   // 100 MHz clock and a free-running cycle counter for timing stamps
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single comparison point: every check in the bench goes through here
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // One store cycle to the transmit register; accepted bytes go onto the scoreboard
   task automatic applyStimulus(input logic [7:0] data, input bit accept);
      address    = 8'hF0;
      input_data = {8'hEE, data};
      write_en   = 1'b1;
      @(posedge clk);
      #1;
      write_en   = 1'b0;
      address    = 8'h00;
      input_data = '0;
      if (accept) expQ.push_back(data);
   endtask

   // One status load cycle; the value is sampled combinationally before the edge
   task automatic readStatus(input string tag, input logic [15:0] expected);
      address = 8'hF1;
      read_en = 1'b1;
      #1;
      checkOutput(tag, 32'(output_data), 32'(expected));
      @(posedge clk);
      #1;
      read_en = 1'b0;
      address = 8'h00;
   endtask

   task automatic idleCycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Expected line level for bit-time k of a frame carrying byte d
   function automatic logic expBit(input logic [7:0] d, input int k);
      if (k == 0) return 1'b0;
      if (k <= 8) return d[k-1];
`ifdef UART_TX_PARITY_EN
      if (k == 9) return ^d;
`endif
      return 1'b1;
   endfunction

   // Independent receiver: finds the start edge, samples mid-bit, checks framing and the byte
   bit         monActive = 1'b0;
   int         monCnt = 0;
   int         monBit = 0;
   logic [7:0] monData = '0;
   logic [7:0] expByte;

   always @(negedge clk) begin
      if (rst) begin
         monActive = 1'b0;
      end else begin
         if (!monActive) begin
            if (line === 1'b0) begin
               monActive = 1'b1;
               monCnt    = 0;
               monData   = '0;
               startStamps.push_back(cyc);
            end
         end else begin
            monCnt++;
         end
         if (monActive && ((monCnt % DIV) == DIV / 2)) begin
            monBit = monCnt / DIV;
            if (monBit == 0) begin
               checkOutput("start bit level", 32'(line), 32'd0);
            end else if (monBit <= 8) begin
               monData[monBit-1] = line;
`ifdef UART_TX_PARITY_EN
            end else if (monBit == 9) begin
               checkOutput("parity bit", 32'(line), 32'(^monData));
`endif
            end else begin
               checkOutput("stop bit level", 32'(line), 32'd1);
               checkOutput("scoreboard entry available", 32'(expQ.size() != 0), 32'd1);
               if (expQ.size() != 0) begin
                  expByte = expQ.pop_front();
                  checkOutput("received byte", 32'(monData), 32'(expByte));
               end
               monFrames++;
               monActive = 1'b0;
            end
         end
      end
   end

   // Hard time limit so a stuck design still produces a verdict
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequence
   initial begin
      int lineErr;
      int busyCnt;

      // Reset state
      idleCycles(3);
      checkOutput("line high in reset", 32'(line), 32'd1);
      readStatus("status in reset", 16'h0000);
      rst = 1'b0;
      idleCycles(5);
      checkOutput("line idle after reset", 32'(line), 32'd1);
      readStatus("status idle", 16'h0000);

      // Single byte: exact latency and bit-by-bit waveform of the whole frame
      applyStimulus(8'h55, 1'b1);
      checkOutput("line high one cycle after write", 32'(line), 32'd1);
      idleCycles(1);
      checkOutput("start bit two cycles after write", 32'(line), 32'd0);
      lineErr = 0;
      for (int c = 0; c < FRAME; c++) begin
         if (line !== expBit(8'h55, c / DIV)) lineErr++;
         idleCycles(1);
      end
      checkOutput("frame 0x55 waveform errors", 32'(lineErr), 32'd0);
      checkOutput("line high after frame", 32'(line), 32'd1);
      readStatus("status idle after 0x55", 16'h0000);
      checkOutput("frames after 0x55", 32'(monFrames), 32'd1);

      // Back-to-back bytes: no gap between frames, busy held throughout
      startStamps.delete();
      applyStimulus(8'hA1, 1'b1);
      applyStimulus(8'h02, 1'b1);
      applyStimulus(8'h03, 1'b1);
      address = 8'hF1;
      read_en = 1'b0;
      #1;
      checkOutput("read_en low at status address", 32'(output_data), 32'd0);
      address = 8'hF0;
      read_en = 1'b1;
      #1;
      checkOutput("read at transmit address", 32'(output_data), 32'd0);
      read_en = 1'b0;
      address = 8'h00;
      readStatus("status during burst", 16'h0002);
      address = 8'hF1;
      read_en = 1'b1;
      #1;
      busyCnt = 0;
      while (output_data[1] === 1'b1 && busyCnt < 4 * FRAME) begin
         busyCnt++;
         @(posedge clk);
         #1;
      end
      // Busy from the first write edge until IDLE one edge after the third frame ends, counted from the fourth edge
      checkOutput("busy cycles over burst", 32'(busyCnt), 32'(3 * FRAME - 2));
      checkOutput("status after burst", 32'(output_data), 32'd0);
      read_en = 1'b0;
      address = 8'h00;
      idleCycles(2);
      checkOutput("frames after burst", 32'(monFrames), 32'd4);
      checkOutput("start stamps in burst", 32'(startStamps.size()), 32'd3);
      if (startStamps.size() == 3) begin
         checkOutput("gap frame1 to frame2", 32'(startStamps[1] - startStamps[0]), 32'(FRAME));
         checkOutput("gap frame2 to frame3", 32'(startStamps[2] - startStamps[1]), 32'(FRAME));
      end

      // Overflow: one byte in flight, four queued, sixth dropped
      applyStimulus(8'h37, 1'b1);
      applyStimulus(8'h11, 1'b1);
      applyStimulus(8'h22, 1'b1);
      applyStimulus(8'h44, 1'b1);
      applyStimulus(8'h88, 1'b1);
      applyStimulus(8'h99, 1'b0);
      readStatus("status after overflow", 16'h0007);
      readStatus("status after ovf cleared", 16'h0003);

      // Reset in the middle of data bit 3 of 0x37, which is a zero bit
      idleCycles(3900 - 7);
      checkOutput("line low in data bit 3", 32'(line), 32'd0);
      rst = 1'b1;
      #1;
      checkOutput("line high immediately on reset", 32'(line), 32'd1);
      address = 8'hF1;
      read_en = 1'b1;
      #1;
      checkOutput("status while reset", 32'(output_data), 32'd0);
      read_en = 1'b0;
      address = 8'h00;
      expQ.delete();
      idleCycles(2);
      rst = 1'b0;
      idleCycles(3);
      checkOutput("line high after mid-frame reset", 32'(line), 32'd1);
      applyStimulus(8'h5A, 1'b1);
      idleCycles(FRAME + 20);
      checkOutput("frames after reset recovery", 32'(monFrames), 32'd5);
      readStatus("queue discarded by reset", 16'h0000);
      checkOutput("scoreboard drained", 32'(expQ.size()), 32'd0);

`ifdef UART_TX_PARITY_EN
      // Parity frames: 0x07 carries parity 1, 0x03 carries parity 0
      startStamps.delete();
      applyStimulus(8'h07, 1'b1);
      applyStimulus(8'h03, 1'b1);
      idleCycles(2 * FRAME + 20);
      checkOutput("frames after parity bytes", 32'(monFrames), 32'd7);
      if (startStamps.size() == 2) begin
         checkOutput("parity frame length", 32'(startStamps[1] - startStamps[0]), 32'd9548);
      end
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_tx_port.md
UART_TX_PORT -- requirements
Module: uart_tx_port

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, meaning CLK frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, meaning line bit rate.
REQ-003 SHALL have parameter TX_ADDR, default 8'hF0, meaning data-memory address of the transmit data register.
REQ-004 SHALL have parameter STAT_ADDR, default 8'hF1, meaning data-memory address of the status register.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning transmit FIFO entries, power of two, 2..16.
REQ-006 SHALL have port CLK, input, 1, the single clock; all state on its rising edge.
REQ-007 SHALL have port RST, input, 1, asynchronous active-high reset.
REQ-008 SHALL have port address, input, 8, data-memory address.
REQ-009 SHALL have port write_en, input, 1, store strobe for one cycle.
REQ-010 SHALL have port read_en, input, 1, load strobe.
REQ-011 SHALL have port input_data, input, 16, store data; bits [7:0] are used.
REQ-012 SHALL have port output_data, output, 16, status read data.
REQ-013 SHALL have port UART_RXD_OUT, output, 1, serial line to the host, idle high.

Function
REQ-014 SHALL compute DIV = CLK_HZ/BAUD, truncated, as the CLK cycles per bit.
REQ-015 SHALL push input_data[7:0] into the FIFO when write_en=1, address=TX_ADDR and the FIFO is not full.
REQ-016 SHALL drop a write to TX_ADDR when the FIFO is full, and SHALL set sticky status bit ovf.
REQ-017 SHALL drive output_data = {13'b0, ovf, busy, full} combinationally when read_en=1 and address=STAT_ADDR, and 16'h0000 otherwise.
REQ-018 SHALL clear ovf on the cycle after a status read; if an overflow occurs in the same cycle as the read, ovf SHALL remain set.
REQ-019 SHALL implement FSM IDLE -> START -> DATA -> (PARITY) -> STOP -> IDLE.
REQ-020 IDLE: line high; when the FIFO is not empty, pop one byte into the shift register and enter START on the next cycle.
REQ-021 START: line low for DIV cycles.
REQ-022 DATA: 8 bits, LSB first, each held for DIV cycles, with a 3-bit bit counter.
REQ-023 STOP: line high for DIV cycles; then pop the next byte directly into START if the FIFO is non-empty, otherwise enter IDLE.
REQ-024 busy SHALL be 1 in any state other than IDLE, or while the FIFO is non-empty.
REQ-025 A push and a pop in the same cycle SHALL both complete; FIFO occupancy is unchanged and full is unaffected.
REQ-026 FIFO pointers SHALL wrap modulo FIFO_DEPTH; full/empty SHALL be derived from an occupancy counter of width clog2(FIFO_DEPTH)+1.
REQ-027 Latency from the write cycle to the falling edge of the start bit SHALL be 2 CLK cycles when idle.

Reset
REQ-028 On RST=1, without waiting for a clock edge: state=IDLE, UART_RXD_OUT=1, FIFO empty, ovf=0, baud and bit counters=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately, with the line high; queued bytes SHALL be discarded.
REQ-030 The first byte after RST deasserts SHALL be framed normally, with no glitch on UART_RXD_OUT.

Configuration
REQ-031 With macro UART_TX_PARITY_EN defined: a PARITY state of DIV cycles SHALL follow DATA, carrying the even-parity bit (XOR of the 8 data bits).
REQ-032 Without UART_TX_PARITY_EN: no PARITY state; the frame is 8N1, 10 bit-times.

Structure
REQ-033 Package uart_pkg SHALL hold the tx_state_t enum, the bit-count constant 8, and the status bit index constants (FULL=0, BUSY=1, OVF=2).
REQ-034 The FIFO SHALL be sub-module uart_tx_fifo (push, pop, din, dout, full, empty), reset by the same RST.

Verification (CLK_HZ=100 MHz, BAUD=115200, DIV=868)
REQ-035 Write 8'h55 to 8'hF0 -> line low 868 cycles starting 2 cycles after the write, then bits 1,0,1,0,1,0,1,0, then high 868; total 8680 cycles.
REQ-036 Write 8'hA1, 8'h02, 8'h03 back-to-back -> three frames with no idle gap between the stop bit and the next start bit; busy=1 throughout, then 0.
REQ-037 Write 6 bytes while transmitting (depth 4) -> full=1, extra bytes dropped, status read returns 16'h0007, next read returns 16'h0003.
REQ-038 Assert RST during DATA bit 3 -> line high the same cycle, status 16'h0000, next write transmits correctly.
REQ-039 With UART_TX_PARITY_EN, write 8'h07 -> parity bit 1 and an 11-bit frame (9548 cycles); write 8'h03 -> parity bit 0.
REQ-040 A read from any address other than 8'hF1, or with read_en=0 -> output_data=16'h0000.
